// File: rtl/dut_capture_pkg.sv
// rtl/dut_capture_pkg.sv - shared state encoding and width helpers for the ADC capture packer
package dut_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } cap_state_e;

  localparam int unsigned ADC_MAX_DATA_SIZE_DFLT = 16;
  localparam int unsigned BRAM_WORD_NUM_DFLT     = 16;

  // Packed output word width for a given sample width and lane count.
  function automatic int unsigned word_width(input int unsigned sample_w, input int unsigned lanes);
    return sample_w * lanes;
  endfunction

  // Lane counter width; lane count is a power of two, at least 2.
  function automatic int unsigned lane_width(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

  localparam int unsigned WORD_W = word_width(ADC_MAX_DATA_SIZE_DFLT, BRAM_WORD_NUM_DFLT);
  localparam int unsigned LANE_W = lane_width(BRAM_WORD_NUM_DFLT);

endpackage

// File: rtl/dut_capture_hold.sv
// rtl/dut_capture_hold.sv - one-entry valid/ready holding register with drop detection
module dut_capture_hold
  import dut_capture_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             xfer;

  assign xfer   = valid_q & ready_i;
  // A new word can only land if the slot is empty or draining this edge.
  assign drop_o = load_i & valid_q & ~ready_i;

  // Next-state for the slot: clear wins, then load, then drain on transfer.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i && !drop_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; data only changes on an accepted load so it is stable while valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dut_capture_format.sv
// rtl/dut_capture_format.sv - decimating ADC sample packer feeding the BRAM writer
module dut_capture_format
  import dut_capture_pkg::*;
#(
  parameter int unsigned ADC_MAX_DATA_SIZE = 16,
  parameter int unsigned BRAM_WORD_NUM     = 16,
  parameter int unsigned LEN_WIDTH         = 16,
  parameter int unsigned DEC_WIDTH         = 4
) (
  input  logic                                       dut_capture_clk,
  input  logic                                       dut_capture_reset_n,
  input  logic [ADC_MAX_DATA_SIZE-1:0]               dut_capture_data_in,
  input  logic                                       dut_capture_system_ready,
  input  logic                                       dut_capture_start,
  input  logic [LEN_WIDTH-1:0]                       dut_capture_len,
  input  logic [DEC_WIDTH-1:0]                       dut_capture_decimate,
  input  logic                                       dut_capture_bram_ready,
  output logic                                       dut_capture_bram_data_en,
  output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] dut_capture_bram_data_out,
  output logic                                       dut_capture_busy,
  output logic                                       dut_capture_done,
  output logic                                       dut_capture_overflow
);

  localparam int unsigned WORD_BITS = word_width(ADC_MAX_DATA_SIZE, BRAM_WORD_NUM);
  localparam int unsigned LANE_BITS = lane_width(BRAM_WORD_NUM);
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(BRAM_WORD_NUM - 1);

  cap_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [DEC_WIDTH-1:0]   dec_q, dec_d;
  logic [DEC_WIDTH-1:0]   dec_cnt_q, dec_cnt_d;
  logic [LANE_BITS-1:0]   lane_q, lane_d;
  logic [WORD_BITS-1:0]   pack_q, pack_d;
  logic                   full_q, full_d;
  logic                   overflow_q, overflow_d;
  logic                   done_q, done_d;

  logic                   hold_clear;
  logic                   hold_load;
  logic                   hold_valid;
  logic                   hold_drop;
  logic [WORD_BITS-1:0]   hold_data;

  // Control FSM, decimation/lane/word counters and sample packing.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    dec_d      = dec_q;
    dec_cnt_d  = dec_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    full_d     = 1'b0;
    overflow_d = overflow_q | hold_drop;
    done_d     = 1'b0;
    hold_clear = 1'b0;
    hold_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dut_capture_start && dut_capture_system_ready) begin
          len_d      = dut_capture_len;
          dec_d      = dut_capture_decimate;
          dec_cnt_d  = '0;
          lane_d     = '0;
          word_cnt_d = '0;
          overflow_d = 1'b0;
          state_d    = (dut_capture_len == '0) ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (!dut_capture_system_ready) begin
          hold_clear = 1'b1;
          state_d    = IDLE;
        end else begin
          // A word completed on the previous edge moves to the holding slot now.
          hold_load = full_q;
          dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + 1'b1;
          if (dec_cnt_q == '0) begin
            pack_d = {dut_capture_data_in, pack_q[WORD_BITS-1:ADC_MAX_DATA_SIZE]};
            lane_d = lane_q + 1'b1;
            if (lane_q == LAST_LANE) begin
              full_d     = 1'b1;
              word_cnt_d = word_cnt_q + 1'b1;
              if (word_cnt_d == len_q) begin
                state_d = DRAIN;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (!dut_capture_system_ready) begin
          hold_clear = 1'b1;
          state_d    = IDLE;
        end else begin
          hold_load = full_q;
          if (!full_q && !hold_valid) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge dut_capture_clk or negedge dut_capture_reset_n) begin
    if (!dut_capture_reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      dec_q      <= '0;
      dec_cnt_q  <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      dec_q      <= dec_d;
      dec_cnt_q  <= dec_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  dut_capture_hold #(
    .WIDTH(WORD_BITS)
  ) u_hold (
    .clk_i   (dut_capture_clk),
    .rst_ni  (dut_capture_reset_n),
    .clear_i (hold_clear),
    .load_i  (hold_load),
    .data_i  (pack_q),
    .ready_i (dut_capture_bram_ready),
    .valid_o (hold_valid),
    .data_o  (hold_data),
    .drop_o  (hold_drop)
  );

  assign dut_capture_bram_data_en  = hold_valid;
  assign dut_capture_bram_data_out = hold_data;
  assign dut_capture_busy          = (state_q != IDLE);
  assign dut_capture_done          = done_q;
  assign dut_capture_overflow      = overflow_q;

endmodule
